sdram_arb2: RTL and testbench

SDRAM_ARB2 -- requirements
Module: sdram_arb2

---
 rtl/sdram_arb2.sv | 159 +++++++++++++++
 tb/tb_sdram_arb2.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arb2.sv
// Two-master arbiter in front of a single SDRAM controller port; optional macro SDRAM_ARB2_FIXED_PRIO_EN.
// Latency: a request seen in IDLE is presented on s_* one cycle later; one transaction outstanding at a time.
// Backpressure: s_waitrequest holds the registered s_* command; the winner's waitrequest drops only in its acceptance cycle.
module sdram_arb2 #(
    parameter int AW = 25,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   m0_address,
    input  logic            m0_read,
    input  logic            m0_write,
    input  logic [DW-1:0]   m0_writedata,
    input  logic [DW/8-1:0] m0_byteenable,
    output logic            m0_waitrequest,
    output logic [DW-1:0]   m0_readdata,
    output logic            m0_readdatavalid,
    input  logic [AW-1:0]   m1_address,
    input  logic            m1_read,
    input  logic            m1_write,
    input  logic [DW-1:0]   m1_writedata,
    input  logic [DW/8-1:0] m1_byteenable,
    output logic            m1_waitrequest,
    output logic [DW-1:0]   m1_readdata,
    output logic            m1_readdatavalid,
    output logic [AW-1:0]   s_address,
    output logic            s_read,
    output logic            s_write,
    output logic [DW-1:0]   s_writedata,
    output logic [DW/8-1:0] s_byteenable,
    input  logic            s_waitrequest,
    input  logic [DW-1:0]   s_readdata,
    input  logic            s_readdatavalid,
    output logic            grant
);

    localparam int BW = DW / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [BW-1:0]   be_q, be_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;

    logic            req0, req1, win;
    logic            accept;
    logic            rd_return;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Next-state: pick a winner in IDLE, hold the command through stalls, wait for read return.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        win     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
`ifdef SDRAM_ARB2_FIXED_PRIO_EN
                    win = 1'b0;
`else
                    // Round robin: the master not served last time goes first.
                    win = ~grant_q;
`endif
                end else begin
                    win = req1;
                end
                if (req0 || req1) begin
                    grant_d = win;
                    state_d = ISSUE;
                    if (win) begin
                        addr_d  = m1_address;
                        wdata_d = m1_writedata;
                        be_d    = m1_byteenable;
                        rd_d    = m1_read;
                        wr_d    = m1_write;
                    end else begin
                        addr_d  = m0_address;
                        wdata_d = m0_writedata;
                        be_d    = m0_byteenable;
                        rd_d    = m0_read;
                        wr_d    = m0_write;
                    end
                end
            end
            ISSUE: begin
                if (!s_waitrequest) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = rd_q ? RDWAIT : IDLE;
                end
            end
            RDWAIT: begin
                if (s_readdatavalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // FSM state and registered controller command; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Acceptance and read return are only meaningful in their own states, so strays are dropped.
    assign accept    = (state_q == ISSUE) && !s_waitrequest;
    assign rd_return = (state_q == RDWAIT) && s_readdatavalid;

    assign m0_waitrequest   = !(accept && !grant_q);
    assign m1_waitrequest   = !(accept && grant_q);
    assign m0_readdatavalid = rd_return && !grant_q;
    assign m1_readdatavalid = rd_return && grant_q;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    assign s_address   = addr_q;
    assign s_writedata = wdata_q;
    assign s_byteenable = be_q;
    assign s_read      = rd_q;
    assign s_write     = wr_q;
    assign grant       = grant_q;

endmodule

// File: tb/tb_sdram_arb2.sv
module tb_sdram_arb2;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [24:0] s_address;
    logic        s_read, s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic        grant;

    sdram_arb2 dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        g;
        logic        wr;
        logic [24:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } txn_t;

    typedef struct {
        logic        m;
        logic [31:0] d;
    } rd_t;

    txn_t txn_q[$];
    rd_t  rd_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    // slave model controls, written only by the test sequence
    int          stall_cycles = 0;
    int          rd_delay     = 1;
    logic [31:0] rd_data      = 32'h0;
    int          stray_req    = 0;

    // monitor state
    logic        prev_hold = 1'b0;
    logic [24:0] prev_addr;
    logic [31:0] prev_wdata;
    logic [3:0]  prev_be;
    logic        prev_rd, prev_wr;
    int          hold_cnt  = 0;
    int          last_hold = 0;
    logic        rd_outstanding = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int n, input logic rd, input logic wr,
                         input logic [24:0] a, input logic [31:0] d, input logic [3:0] be);
        if (n == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
        end
    endtask

    // Present a request and hold it until the arbiter accepts it (bounded).
    task automatic m_req(input int n, input logic wr, input logic [24:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        int   cyc;
        logic wait_n;
        drive(n, !wr, wr, a, d, be);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            wait_n = (n == 0) ? m0_waitrequest : m1_waitrequest;
        end while (wait_n && cyc < 400);
        check("accept_within_budget", !wait_n, 1'b1);
        @(posedge clk);
        #1;
        drive(n, 1'b0, 1'b0, a, d, be);
    endtask

    task automatic push_txn(input logic g, input logic wr, input logic [24:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        txn_t t;
        t.g = g; t.wr = wr; t.addr = a; t.data = d; t.be = be;
        txn_q.push_back(t);
    endtask

    task automatic push_rd(input logic m, input logic [31:0] d);
        rd_t r;
        r.m = m; r.d = d;
        rd_q.push_back(r);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_read"}, s_read, 1'b0);
        check({tag, "_s_write"}, s_write, 1'b0);
        check({tag, "_s_address"}, s_address, 25'h0);
        check({tag, "_s_writedata"}, s_writedata, 32'h0);
        check({tag, "_s_byteenable"}, s_byteenable, 4'h0);
        check({tag, "_grant"}, grant, 1'b1);
        check({tag, "_m0_wait"}, m0_waitrequest, 1'b1);
        check({tag, "_m1_wait"}, m1_waitrequest, 1'b1);
        check({tag, "_m0_rdv"}, m0_readdatavalid, 1'b0);
        check({tag, "_m1_rdv"}, m1_readdatavalid, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Slave model: stalls each command for stall_cycles, returns read data rd_delay cycles after acceptance.
    initial begin : slave
        int st_cnt;
        int rd_cnt;
        int stray_ack;
        st_cnt = 0; rd_cnt = 0; stray_ack = 0;
        s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            s_readdatavalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    s_readdatavalid = 1'b1;
                    s_readdata = rd_data;
                end
            end
            if (stray_ack != stray_req) begin
                stray_ack = stray_req;
                s_readdatavalid = 1'b1;
                s_readdata = 32'hBAD0BAD0;
            end
            if (s_read || s_write) begin
                if (st_cnt < stall_cycles) begin
                    s_waitrequest = 1'b1;
                    st_cnt++;
                end else begin
                    s_waitrequest = 1'b0;
                    st_cnt = 0;
                    if (s_read) rd_cnt = rd_delay;
                end
            end else begin
                st_cnt = 0;
                s_waitrequest = 1'b0;
            end
        end
    end

    // Monitor: waitrequest rule, stall stability, acceptance scoreboard, read-return scoreboard.
    always @(negedge clk) begin
        logic acc;
        txn_t t;
        rd_t  r;
        acc = (s_read || s_write) && !s_waitrequest;
        check("m0_waitrequest_rule", m0_waitrequest, !(acc && grant == 1'b0));
        check("m1_waitrequest_rule", m1_waitrequest, !(acc && grant == 1'b1));
        if (prev_hold && !rst) begin
            check("stall_addr_stable", s_address, prev_addr);
            check("stall_wdata_stable", s_writedata, prev_wdata);
            check("stall_be_stable", s_byteenable, prev_be);
            check("stall_cmd_stable", {s_read, s_write}, {prev_rd, prev_wr});
        end
        if (acc) begin
            check("one_outstanding", rd_outstanding, 1'b0);
            if (txn_q.size() == 0) begin
                check("txn_unexpected", 1'b1, 1'b0);
            end else begin
                t = txn_q.pop_front();
                check("txn_grant", grant, t.g);
                check("txn_cmd", {s_read, s_write}, {!t.wr, t.wr});
                check("txn_addr", s_address, t.addr);
                check("txn_be", s_byteenable, t.be);
                if (t.wr) check("txn_wdata", s_writedata, t.data);
            end
            last_hold = hold_cnt;
            hold_cnt = 0;
            if (s_read) rd_outstanding = 1'b1;
        end
        if (m0_readdatavalid || m1_readdatavalid) begin
            if (rd_q.size() == 0) begin
                check("rdv_unexpected", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
            end else begin
                r = rd_q.pop_front();
                check("rdv_master", {m1_readdatavalid, m0_readdatavalid}, r.m ? 2'b10 : 2'b01);
                check("rdv_data", r.m ? m1_readdata : m0_readdata, r.d);
            end
            rd_outstanding = 1'b0;
        end
        prev_hold  = (s_read || s_write) && s_waitrequest;
        if (prev_hold) hold_cnt++;
        prev_addr  = s_address;
        prev_wdata = s_writedata;
        prev_be    = s_byteenable;
        prev_rd    = s_read;
        prev_wr    = s_write;
        if (rst) begin
            rd_outstanding = 1'b0;
            hold_cnt = 0;
            prev_hold = 1'b0;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : test
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 25'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 25'h0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        do_reset();

        // single write with latency and one-cycle waitrequest pulse
        stall_cycles = 0;
        push_txn(1'b0, 1'b1, 25'h10, 32'hDEADBEEF, 4'hF);
        fork
            m_req(0, 1'b1, 25'h10, 32'hDEADBEEF, 4'hF);
            begin
                @(negedge clk);
                check("single_t_s_write", s_write, 1'b0);
                check("single_t_m0_wait", m0_waitrequest, 1'b1);
                @(negedge clk);
                check("single_t1_s_write", s_write, 1'b1);
                check("single_t1_m0_wait", m0_waitrequest, 1'b0);
                check("single_t1_grant", grant, 1'b0);
                @(negedge clk);
                check("single_t2_m0_wait", m0_waitrequest, 1'b1);
                check("single_t2_s_write", s_write, 1'b0);
            end
        join

        // contention: both masters write four times each
        do_reset();
        for (int i = 0; i < 4; i++) begin
`ifdef SDRAM_ARB2_FIXED_PRIO_EN
            push_txn(1'b0, 1'b1, 25'h100 + 25'(i), 32'hA0000000 + 32'(i), 4'h3);
`else
            push_txn(1'b0, 1'b1, 25'h100 + 25'(i), 32'hA0000000 + 32'(i), 4'h3);
            push_txn(1'b1, 1'b1, 25'h200 + 25'(i), 32'hB0000000 + 32'(i), 4'hC);
`endif
        end
`ifdef SDRAM_ARB2_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++)
            push_txn(1'b1, 1'b1, 25'h200 + 25'(i), 32'hB0000000 + 32'(i), 4'hC);
`endif
        fork
            begin
                for (int i = 0; i < 4; i++)
                    m_req(0, 1'b1, 25'h100 + 25'(i), 32'hA0000000 + 32'(i), 4'h3);
            end
            begin
                for (int j = 0; j < 4; j++)
                    m_req(1, 1'b1, 25'h200 + 25'(j), 32'hB0000000 + 32'(j), 4'hC);
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // read with 3 stall cycles and data returned 5 cycles after acceptance
        stall_cycles = 3;
        rd_delay = 5;
        rd_data = 32'h12345678;
        push_txn(1'b1, 1'b0, 25'h2A, 32'h0, 4'hF);
        push_rd(1'b1, 32'h12345678);
        m_req(1, 1'b0, 25'h2A, 32'h0, 4'hF);
        check("read_stall_cycles", last_hold, 3);
        repeat (8) @(posedge clk);
        #1;
        check("read_returned", rd_q.size(), 0);

        // back-to-back: m0 read outstanding while m1 writes
        stall_cycles = 0;
        rd_delay = 4;
        rd_data = 32'hCAFEF00D;
        push_txn(1'b0, 1'b0, 25'h33, 32'h0, 4'hF);
        push_rd(1'b0, 32'hCAFEF00D);
        push_txn(1'b1, 1'b1, 25'h44, 32'h55AA55AA, 4'h5);
        fork
            m_req(0, 1'b0, 25'h33, 32'h0, 4'hF);
            begin
                @(posedge clk);
                #1;
                m_req(1, 1'b1, 25'h44, 32'h55AA55AA, 4'h5);
                check("b2b_read_before_write", rd_q.size(), 0);
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // stray read return while idle
        @(posedge clk);
        #2;
        stray_req++;
        repeat (3) begin
            @(negedge clk);
            check("stray_m0_rdv", m0_readdatavalid, 1'b0);
            check("stray_m1_rdv", m1_readdatavalid, 1'b0);
        end
        @(posedge clk);
        #1;

        // reset during RDWAIT; the return arrives while reset is held
        stall_cycles = 0;
        rd_delay = 3;
        rd_data = 32'h0BADF00D;
        push_txn(1'b0, 1'b0, 25'h77, 32'h0, 4'hF);
        m_req(0, 1'b0, 25'h77, 32'h0, 4'hF);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_reset_outputs("midread");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("postreset_m0_rdv", m0_readdatavalid, 1'b0);
        end
        @(posedge clk);
        #1;

        // 20-cycle stall during an m0 write, accepted on cycle 21
        stall_cycles = 20;
        push_txn(1'b0, 1'b1, 25'h1ABCDE, 32'h0F0F1234, 4'h9);
        m_req(0, 1'b1, 25'h1ABCDE, 32'h0F0F1234, 4'h9);
        check("stall20_cycles", last_hold, 20);
        stall_cycles = 0;

        repeat (5) @(posedge clk);
        #1;
        check("txn_queue_empty", txn_q.size(), 0);
        check("rd_queue_empty", rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
